uart_rx_sampler: RTL

UART receiver paired with the 8N1 transmitter: recovers bytes from the serial `rx_i` line using a mid-bit sampling counter and hands each byte to the core over a valid/ready handshake with a one-byte holding register. It sits between the board RX pin and the CPU's UART data register. It flags framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx_sampler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register, error pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at each sample point.
module uart_rx_sampler #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 1152000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int BIT_PERIOD =
    (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = BIT_PERIOD / 2;

  localparam logic [15:0] BIT_LAST = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        busy_q;
  logic        hs;
  logic        sample;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from the two cycles before the terminal count
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) |
                  (hist_q[1] & rx_s) |
                  (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  assign hs = valid_q & ready_i;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (hs) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = 16'd0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          state_d   = sample ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = 16'd0;
          shift_d[bit_cnt_q] = sample;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          if (sample) begin
            state_d = IDLE;
            if (!valid_q || hs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            // held-low line must return high before a new frame
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= (state_q != IDLE);
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule
